// File: rtl/param_shift_seq_reg.sv
// param_shift_seq_reg: parameterised shift register with logical/rotate/arithmetic/serial-fill modes,
//   parallel load, serial out, and a start/busy/done engine that shifts N positions, one per clock.
// Ports: clk, rst_n (async active-low), we_n (active-low load), par_in, direction (1 = left),
//   mode (00 log, 01 rot, 10 arith, 11 fill), ser_in, shift_en, start, amount -> data_out, ser_out,
//   busy, done.
// Latency: a load takes 1 cycle; a start with N>0 finishes in N+1 cycles. Outputs are all registered.
// Macro PSR_ROTATE_EN: when defined, mode 01 rotates. When undefined, the rotate logic is left out
//   and mode 01 acts as a logical shift.
module param_shift_seq_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_n,
  input  logic [WIDTH-1:0] par_in,
  input  logic             direction,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             shift_en,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic             run_dir;
  logic [1:0]       run_mode;

  logic             step_dir;
  logic [1:0]       step_mode;
  logic             step_out;
  logic             fill_bit;
  logic [WIDTH-1:0] step_data;

  // One shift step. While RUN is active, the direction and mode come from the values latched at
  // start. While idle, they come from the live inputs. ser_in is always taken live, so a
  // serial-fill run can stream new bits in.
  always_comb begin
    step_dir  = (state == ST_RUN) ? run_dir  : direction;
    step_mode = (state == ST_RUN) ? run_mode : mode;
    step_out  = step_dir ? data_out[WIDTH-1] : data_out[0];
    fill_bit  = 1'b0;
    case (step_mode)
`ifdef PSR_ROTATE_EN
      2'b01:   fill_bit = step_out;                               // out-going bit wraps round
`endif
      2'b10:   fill_bit = step_dir ? 1'b0 : data_out[WIDTH-1];    // sign extension on right only
      2'b11:   fill_bit = ser_in;
      default: fill_bit = 1'b0;
    endcase
    step_data = step_dir ? {data_out[WIDTH-2:0], fill_bit}
                         : {fill_bit, data_out[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      run_dir  <= 1'b0;
      run_mode <= 2'b00;
      data_out <= '0;
      ser_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!we_n) begin
        // A load wins in either state. During RUN it aborts the run without a done pulse.
        data_out <= par_in;
        state    <= ST_IDLE;
        count    <= '0;
      end else if (state == ST_IDLE) begin
        if (start) begin
          if (amount == '0) begin
            done <= 1'b1;
          end else begin
            state    <= ST_RUN;
            count    <= amount;
            run_dir  <= direction;
            run_mode <= mode;
          end
        end else if (shift_en) begin
          data_out <= step_data;
          ser_out  <= step_out;
        end
      end else begin
        data_out <= step_data;
        ser_out  <= step_out;
        count    <= count - 1'b1;
        if (count == CNT_W'(1)) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_param_shift_seq_reg.sv
module tb_param_shift_seq_reg;
  localparam int W = 8;
  localparam int C = 4;

  logic         clk;
  logic         rst_n;
  logic         we_n;
  logic [W-1:0] par_in;
  logic         direction;
  logic [1:0]   mode;
  logic         ser_in;
  logic         shift_en;
  logic         start;
  logic [C-1:0] amount;
  logic [W-1:0] data_out;
  logic         ser_out;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;

  // Behavioural reference state
  logic [W-1:0] m_data;
  logic         m_ser;
  logic         m_busy;
  logic         m_done;
  int           m_cnt;
  logic         m_dir;
  logic [1:0]   m_mode;

  param_shift_seq_reg #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .we_n(we_n), .par_in(par_in), .direction(direction),
    .mode(mode), .ser_in(ser_in), .shift_en(shift_en), .start(start), .amount(amount),
    .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic dir, input logic [1:0] md);
    logic [W-1:0] d;
    logic         o;
    d = m_data;
    o = dir ? d[W-1] : d[0];
`ifndef PSR_ROTATE_EN
    if (md == 2'b01) md = 2'b00;
`endif
    case (md)
      2'b00:   d = dir ? (d << 1) : (d >> 1);
      2'b01:   d = dir ? ((d << 1) | (d >> (W-1))) : ((d >> 1) | (d << (W-1)));
      2'b10:   d = dir ? (d << 1) : W'($signed(d) >>> 1);
      default: d = dir ? ((d << 1) | W'(ser_in)) : ((d >> 1) | (W'(ser_in) << (W-1)));
    endcase
    m_data = d;
    m_ser  = o;
  endtask

  task automatic model_tick();
    logic nd;
    nd = 1'b0;
    if (!rst_n) begin
      m_data = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      return;
    end
    if (!we_n) begin
      m_data = par_in; m_busy = 1'b0; m_cnt = 0;
    end else if (m_busy) begin
      model_step(m_dir, m_mode);
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_busy = 1'b0; nd = 1'b1; end
    end else if (start) begin
      if (amount == '0) nd = 1'b1;
      else begin m_busy = 1'b1; m_cnt = int'(amount); m_dir = direction; m_mode = mode; end
    end else if (shift_en) begin
      model_step(direction, mode);
    end
    m_done = nd;
  endtask

  // One clock: the model consumes the inputs that were set up before the edge,
  // and the DUT is then sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    we_n = 1'b1; start = 1'b0; shift_en = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    we_n = 1'b0; par_in = v; cycle(); we_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); par_in = '0; direction = 1'b0; mode = 2'b00;
    ser_in = 1'b0; amount = '0;
    cycle(); cycle();
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data_out); end
    n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL reset_ser got=%b exp=0", ser_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    load(8'h81);
    n_cmp++; if (data_out !== 8'h81) begin n_err++; $display("FAIL load_data got=%h exp=81", data_out); end
    n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL load_ser got=%b exp=0", ser_out); end
  endtask

  task automatic test_rotate();
    logic [W-1:0] exp_seq [3];
`ifdef PSR_ROTATE_EN
    exp_seq = '{8'h03, 8'h06, 8'h0C};
`else
    exp_seq = '{8'h02, 8'h04, 8'h08};
`endif
    load(8'h81);
    start = 1'b1; mode = 2'b01; direction = 1'b1; amount = 4'd3;
    cycle();
    // Live controls change during the run and must be ignored.
    start = 1'b0; direction = 1'b0; mode = 2'b10; amount = 4'd7;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rot_busy_start got=%b exp=1", busy); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (data_out !== exp_seq[i]) begin n_err++; $display("FAIL rot_step%0d got=%h exp=%h", i, data_out, exp_seq[i]); end
      n_cmp++; if (busy !== (i < 2)) begin n_err++; $display("FAIL rot_busy%0d got=%b exp=%b", i, busy, (i < 2)); end
      n_cmp++; if (done !== (i == 2)) begin n_err++; $display("FAIL rot_done%0d got=%b exp=%b", i, done, (i == 2)); end
    end
    n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL rot_ser got=%b exp=0", ser_out); end
    cycle();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rot_done_once got=%b exp=0", done); end
  endtask

  task automatic test_arith();
    logic [1:0]   mds  [3];
    logic [W-1:0] exps [3];
    mds  = '{2'b10, 2'b00, 2'b01};
    exps = '{8'hE4, 8'h24, 8'h24};
    for (int t = 0; t < 3; t++) begin
      load(8'h90);
      start = 1'b1; mode = mds[t]; direction = 1'b0; amount = 4'd2;
      cycle();
      start = 1'b0;
      cycle(); cycle();
      n_cmp++; if (data_out !== exps[t]) begin n_err++; $display("FAIL arith_m%0d got=%h exp=%h", mds[t], data_out, exps[t]); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL arith_done_m%0d got=%b exp=1", mds[t], done); end
      if (t == 1) begin
        n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL arith_ser got=%b exp=0", ser_out); end
      end
    end
  endtask

  task automatic test_serial_fill();
    load(8'h00);
    shift_en = 1'b1; mode = 2'b11; direction = 1'b1; ser_in = 1'b1;
    repeat (4) cycle();
    shift_en = 1'b0; ser_in = 1'b0;
    n_cmp++; if (data_out !== 8'h0F) begin n_err++; $display("FAIL fill_data got=%h exp=0F", data_out); end
    n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL fill_ser got=%b exp=0", ser_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort_zero();
    load(8'h01);
    start = 1'b1; mode = 2'b00; direction = 1'b1; amount = 4'd5;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    n_cmp++; if (data_out !== 8'h04) begin n_err++; $display("FAIL abort_pre got=%h exp=04", data_out); end
    we_n = 1'b0; par_in = 8'hAA;
    cycle();
    we_n = 1'b1;
    n_cmp++; if (data_out !== 8'hAA) begin n_err++; $display("FAIL abort_data got=%h exp=AA", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", done); end
    cycle();
    n_cmp++; if (done !== 1'b0 || data_out !== 8'hAA) begin n_err++; $display("FAIL abort_after got done=%b data=%h exp done=0 data=AA", done, data_out); end
    start = 1'b1; amount = 4'd0;
    cycle();
    start = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b exp=1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got=%b exp=0", busy); end
    n_cmp++; if (data_out !== 8'hAA) begin n_err++; $display("FAIL zero_data got=%h exp=AA", data_out); end
    cycle();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_once got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    start = 1'b1; mode = 2'b00; direction = 1'b1; amount = 4'd2;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    n_cmp++; if (done !== 1'b1 || data_out !== 8'h04) begin n_err++; $display("FAIL b2b_first got done=%b data=%h exp done=1 data=04", done, data_out); end
    start = 1'b1; amount = 4'd1;
    cycle();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
    cycle();
    n_cmp++; if (done !== 1'b1 || data_out !== 8'h08) begin n_err++; $display("FAIL b2b_second got done=%b data=%h exp done=1 data=08", done, data_out); end
  endtask

  task automatic test_midrun_reset();
    load(8'h01);
    start = 1'b1; mode = 2'b00; direction = 1'b1; amount = 4'd10;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    n_cmp++; if (data_out !== 8'h08 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre got data=%h busy=%b exp data=08 busy=1", data_out, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mid_rst_data got=%h exp=00", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done got=%b exp=0", done); end
    cycle();
    rst_n = 1'b1;
    load(8'h11);
    shift_en = 1'b1; direction = 1'b1; mode = 2'b00;
    cycle();
    shift_en = 1'b0;
    n_cmp++; if (data_out !== 8'h22 || busy !== 1'b0) begin n_err++; $display("FAIL mid_resume got data=%h busy=%b exp data=22 busy=0", data_out, busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we_n      = ($urandom_range(0, 11) != 0);
      par_in    = W'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      amount    = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 15)) : C'($urandom_range(0, 4));
      shift_en  = $urandom_range(0, 1) == 1;
      direction = $urandom_range(0, 1) == 1;
      mode      = 2'($urandom_range(0, 3));
      ser_in    = $urandom_range(0, 1) == 1;
      cycle();
      n_cmp++; if (data_out !== m_data) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, data_out, m_data); end
      n_cmp++; if (ser_out !== m_ser) begin n_err++; $display("FAIL rnd_ser cyc=%0d got=%b exp=%b", i, ser_out, m_ser); end
      n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_busy); end
      n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, done, m_done); end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_data = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    m_dir = 1'b0; m_mode = 2'b00;
    test_reset();
    test_rotate();
    test_arith();
    test_serial_fill();
    test_abort_zero();
    test_back_to_back();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
